// File: rtl/flash_mp_pkg.sv
// flash_mp_pkg
// Shared types for the flash memory-protection operation sequencer.
//   op_e      : host flash operation encoding (3 is reserved)
//   state_e   : sequencer FSM states
//   op_allowed: picks the region-selector enable that matches an operation

package flash_mp_pkg;

   typedef enum logic [1:0] {
      OpRead  = 2'd0,
      OpProg  = 2'd1,
      OpErase = 2'd2,
      OpRsvd  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCheck = 3'd1,
      StIssue = 3'd2,
      StDone  = 3'd3,
      StErr   = 3'd4
   } state_e;

   // A reserved operation is never allowed, whatever the selector says.
   function automatic logic op_allowed(input op_e op, input logic rd_en,
                                       input logic prog_en, input logic erase_en);
      logic ok;
      ok = 1'b0;
      case (op)
         OpRead:  ok = rd_en;
         OpProg:  ok = prog_en;
         OpErase: ok = erase_en;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/flash_mp_addr_cnt.sv
// flash_mp_addr_cnt
// Word address register and word counter for one flash operation.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : start of operation; latch first address and count, clear counter
//   incr_i        : advance to the next word (address wraps modulo 2^AddrW)
//   addr_i, num_i : first word address, word count minus one
//   addr_o        : current word address
//   last_o        : current word is the final word of the operation

module flash_mp_addr_cnt #(
   parameter int AddrW = 16,
   parameter int CntW  = 12
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             incr_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [CntW-1:0]  num_i,
   output logic [AddrW-1:0] addr_o,
   output logic             last_o
);

   logic [AddrW-1:0] addr_q;
   logic [CntW-1:0]  cnt_q;
   logic [CntW-1:0]  num_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
         cnt_q  <= '0;
         num_q  <= '0;
      end else if (load_i) begin
         addr_q <= addr_i;
         cnt_q  <= '0;
         num_q  <= num_i;
      end else if (incr_i) begin
         addr_q <= addr_q + AddrW'(1);
         cnt_q  <= cnt_q + CntW'(1);
      end
   end

   assign addr_o = addr_q;
   assign last_o = (cnt_q == num_q);

endmodule

// File: rtl/flash_mp_op_ctrl.sv
// flash_mp_op_ctrl
// Initiator-side sequencer for flash read/program/erase. Each word is checked
// against the region selector before being issued to the PHY; a denied word or
// reserved operation ends the operation with an error pulse.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   op_start_i/op_type_i/op_addr_i/op_num_words_i : host request (count is N-1)
//   mp_req_o, mp_addr_o           : address-check strobe and address
//   mp_rd_en_i/mp_prog_en_i/mp_erase_en_i : combinational selector enables
//   phy_req_o/phy_op_o/phy_addr_o/phy_ack_i : PHY handshake
//   busy_o, op_done_o, op_err_o   : status
//   err_addr_o                    : last denied address
// Build option: FLASH_MP_ERR_ADDR_EN implements the err_addr_o register;
// without it err_addr_o is constant 0.
//
// state   | meaning
// --------+---------------------------------------------------------
// StIdle  | waiting for op_start_i
// StCheck | current word presented to the region selector
// StIssue | PHY request held until phy_ack_i
// StDone  | one-cycle completion pulse
// StErr   | one-cycle completion + error pulse

module flash_mp_op_ctrl
   import flash_mp_pkg::*;
#(
   parameter int AddrW = 16,
   parameter int CntW  = 12
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             op_start_i,
   input  logic [1:0]       op_type_i,
   input  logic [AddrW-1:0] op_addr_i,
   input  logic [CntW-1:0]  op_num_words_i,
   output logic             mp_req_o,
   output logic [AddrW-1:0] mp_addr_o,
   input  logic             mp_rd_en_i,
   input  logic             mp_prog_en_i,
   input  logic             mp_erase_en_i,
   output logic             phy_req_o,
   output logic [1:0]       phy_op_o,
   output logic [AddrW-1:0] phy_addr_o,
   input  logic             phy_ack_i,
   output logic             busy_o,
   output logic             op_done_o,
   output logic             op_err_o,
   output logic [AddrW-1:0] err_addr_o
);

   state_e           state_q, state_d;
   op_e              op_q;
   logic             load, incr, last;
   logic [AddrW-1:0] addr;

   flash_mp_addr_cnt #(.AddrW(AddrW), .CntW(CntW)) u_addr_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .incr_i (incr),
      .addr_i (op_addr_i),
      .num_i  (op_num_words_i),
      .addr_o (addr),
      .last_o (last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         op_q    <= OpRead;
      end else begin
         state_q <= state_d;
         if (load) op_q <= op_e'(op_type_i);
      end
   end

   // Outputs decode from the state register only, so an async reset drops
   // both request strobes immediately.
   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      incr       = 1'b0;
      mp_req_o   = 1'b0;
      mp_addr_o  = '0;
      phy_req_o  = 1'b0;
      phy_op_o   = '0;
      phy_addr_o = '0;
      busy_o     = 1'b1;
      op_done_o  = 1'b0;
      op_err_o   = 1'b0;
      case (state_q)
         StIdle: begin
            busy_o = 1'b0;
            if (op_start_i) begin
               load    = 1'b1;
               state_d = StCheck;
            end
         end
         StCheck: begin
            mp_req_o  = 1'b1;
            mp_addr_o = addr;
            state_d   = op_allowed(op_q, mp_rd_en_i, mp_prog_en_i, mp_erase_en_i)
                        ? StIssue : StErr;
         end
         StIssue: begin
            phy_req_o  = 1'b1;
            phy_op_o   = op_q;
            phy_addr_o = addr;
            if (phy_ack_i) begin
               // Erase is a single PHY request regardless of the word count.
               if (op_q == OpErase || last) begin
                  state_d = StDone;
               end else begin
                  incr    = 1'b1;
                  state_d = StCheck;
               end
            end
         end
         StDone: begin
            op_done_o = 1'b1;
            state_d   = StIdle;
         end
         StErr: begin
            op_done_o = 1'b1;
            op_err_o  = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef FLASH_MP_ERR_ADDR_EN
   logic [AddrW-1:0] err_addr_q;

   // Captured on the denial itself so the address is already valid while
   // op_err_o is pulsing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_addr_q <= '0;
      end else if (state_q == StCheck && state_d == StErr) begin
         err_addr_q <= addr;
      end
   end

   assign err_addr_o = err_addr_q;
`else
   assign err_addr_o = '0;
`endif

endmodule

// File: tb/tb_flash_mp_op_ctrl.sv
module tb_flash_mp_op_ctrl;

   typedef struct packed {
      logic        mp_req;
      logic [15:0] mp_addr;
      logic        phy_req;
      logic [1:0]  phy_op;
      logic [15:0] phy_addr;
      logic        busy;
      logic        done;
      logic        err;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        op_start_i;
   logic [1:0]  op_type_i;
   logic [15:0] op_addr_i;
   logic [11:0] op_num_words_i;
   logic        mp_req_o;
   logic [15:0] mp_addr_o;
   logic        mp_rd_en_i, mp_prog_en_i, mp_erase_en_i;
   logic        phy_req_o;
   logic [1:0]  phy_op_o;
   logic [15:0] phy_addr_o;
   logic        phy_ack_i;
   logic        busy_o, op_done_o, op_err_o;
   logic [15:0] err_addr_o;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          done_cyc = -1;
   int          req_cnt = 0;
   int          ack_dly = 0;
   logic        checking = 1'b0;
   logic        deny_en = 1'b0;
   logic [15:0] deny_addr = '0;
   logic [15:0] exp_err_addr = '0;
   logic        phy_prev = 1'b0;
   exp_t        exp_q[$];
   logic [15:0] obs_q[$];

   flash_mp_op_ctrl #(.AddrW(16), .CntW(12)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .op_start_i     (op_start_i),
      .op_type_i      (op_type_i),
      .op_addr_i      (op_addr_i),
      .op_num_words_i (op_num_words_i),
      .mp_req_o       (mp_req_o),
      .mp_addr_o      (mp_addr_o),
      .mp_rd_en_i     (mp_rd_en_i),
      .mp_prog_en_i   (mp_prog_en_i),
      .mp_erase_en_i  (mp_erase_en_i),
      .phy_req_o      (phy_req_o),
      .phy_op_o       (phy_op_o),
      .phy_addr_o     (phy_addr_o),
      .phy_ack_i      (phy_ack_i),
      .busy_o         (busy_o),
      .op_done_o      (op_done_o),
      .op_err_o       (op_err_o),
      .err_addr_o     (err_addr_o)
   );

   always #5 clk_i = ~clk_i;

   // Combinational region selector: one address may be denied for all ops.
   always_comb begin
      mp_rd_en_i    = !(deny_en && mp_addr_o == deny_addr);
      mp_prog_en_i  = mp_rd_en_i;
      mp_erase_en_i = mp_rd_en_i;
   end

   // PHY responder: ack after ack_dly cycles of a held request.
   assign phy_ack_i = phy_req_o && (req_cnt == ack_dly);
   always_ff @(posedge clk_i) req_cnt <= (phy_req_o && !phy_ack_i) ? req_cnt + 1 : 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle compare against the expected trace; empty trace means idle.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (checking) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            a = '{mp_req_o, mp_addr_o, phy_req_o, phy_op_o, phy_addr_o,
                  busy_o, op_done_o, op_err_o};
            chk("cycle", 64'(a), 64'(e));
         end
         if (phy_req_o && !phy_prev) obs_q.push_back(phy_addr_o);
         phy_prev = phy_req_o;
         if (op_done_o) done_cyc = cyc;
      end
   end

   // Expected trace from the operation rules: per word one check cycle, then
   // either an error cycle or (ack delay + 1) issue cycles; a done cycle ends it.
   task automatic build_trace(input logic [1:0] t, input logic [15:0] a,
                              input logic [11:0] n, input int dly,
                              input logic den, input logic [15:0] daddr);
      exp_t        e;
      logic [15:0] w;
      int          words;
      logic        failed;
      failed = 1'b0;
      words  = (t == 2'd2) ? 1 : int'(n) + 1;
      for (int i = 0; i < words; i++) begin
         w = a + 16'(i);
         e = '0; e.mp_req = 1'b1; e.mp_addr = w; e.busy = 1'b1;
         exp_q.push_back(e);
         if (t == 2'd3 || (den && w == daddr)) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            exp_q.push_back(e);
            exp_err_addr = w;
            failed = 1'b1;
            break;
         end
         for (int j = 0; j <= dly; j++) begin
            e = '0; e.phy_req = 1'b1; e.phy_op = t; e.phy_addr = w; e.busy = 1'b1;
            exp_q.push_back(e);
         end
      end
      if (!failed) begin
         e = '0; e.busy = 1'b1; e.done = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic start_op(input logic [1:0] t, input logic [15:0] a,
                           input logic [11:0] n, input int dly,
                           input logic den, input logic [15:0] daddr,
                           output int start_cyc);
      @(negedge clk_i); #1;
      obs_q.delete();
      ack_dly = dly; deny_en = den; deny_addr = daddr;
      op_type_i = t; op_addr_i = a; op_num_words_i = n; op_start_i = 1'b1;
      start_cyc = cyc;
      build_trace(t, a, n, dly, den, daddr);
      @(negedge clk_i); #1;
      op_start_i = 1'b0;
   endtask

   task automatic wait_op();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(negedge clk_i); #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         chk("timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic chk_err_addr();
`ifdef FLASH_MP_ERR_ADDR_EN
      chk("err_addr", 64'(err_addr_o), 64'(exp_err_addr));
`else
      chk("err_addr", 64'(err_addr_o), 64'd0);
`endif
   endtask

   initial begin
      int sc, guard;
      rst_ni = 1'b0; op_start_i = 1'b0; op_type_i = '0;
      op_addr_i = '0; op_num_words_i = '0;
      repeat (3) @(negedge clk_i);
      chk("reset", {mp_req_o, mp_addr_o, phy_req_o, phy_op_o, phy_addr_o,
                    busy_o, op_done_o, op_err_o, err_addr_o}, 64'd0);
      #1 rst_ni = 1'b1;
      checking = 1'b1;

      // Read 4 words, immediate ack.
      start_op(2'd0, 16'h0010, 12'd3, 0, 1'b0, 16'h0, sc);
      wait_op();
      chk("rd_done_latency", 64'(done_cyc - sc), 64'd9);
      chk("rd_phy_count", 64'(obs_q.size()), 64'd4);
      chk("rd_last_addr", 64'(obs_q[obs_q.size()-1]), 64'h0013);
      chk_err_addr();

      // Program denied on the second word.
      start_op(2'd1, 16'h0020, 12'd1, 0, 1'b1, 16'h0021, sc);
      wait_op();
      chk("prog_phy_count", 64'(obs_q.size()), 64'd1);
      chk("prog_phy_addr", 64'(obs_q[0]), 64'h0020);
`ifdef FLASH_MP_ERR_ADDR_EN
      chk("prog_err_addr", 64'(err_addr_o), 64'h0021);
`else
      chk("prog_err_addr", 64'(err_addr_o), 64'h0000);
`endif

      // Erase: one request regardless of count; err_addr holds.
      start_op(2'd2, 16'h0100, 12'd5, 1, 1'b0, 16'h0, sc);
      wait_op();
      chk("erase_phy_count", 64'(obs_q.size()), 64'd1);
      chk_err_addr();

      // Address wrap.
      start_op(2'd0, 16'hFFFF, 12'd1, 0, 1'b0, 16'h0, sc);
      wait_op();
      chk("wrap_addr0", 64'(obs_q[0]), 64'hFFFF);
      chk("wrap_addr1", 64'(obs_q[1]), 64'h0000);

      // Reserved op type.
      start_op(2'd3, 16'h0030, 12'd0, 0, 1'b0, 16'h0, sc);
      wait_op();
      chk("rsvd_phy_count", 64'(obs_q.size()), 64'd0);
      chk_err_addr();

      // Start while busy (in Issue) is dropped; ack delayed 4 cycles.
      start_op(2'd0, 16'h0040, 12'd1, 4, 1'b0, 16'h0, sc);
      @(negedge clk_i); #1;
      op_type_i = 2'd2; op_addr_i = 16'h0777; op_num_words_i = 12'd7; op_start_i = 1'b1;
      @(negedge clk_i); #1;
      op_start_i = 1'b0;
      wait_op();
      chk("busy_start_done", 64'(done_cyc - sc), 64'd13);
      chk("busy_start_count", 64'(obs_q.size()), 64'd2);

      // Reset while phy_req_o is high.
      start_op(2'd0, 16'h0200, 12'd2, 3, 1'b0, 16'h0, sc);
      guard = 0;
      while (!phy_req_o && guard < 20) begin @(negedge clk_i); #1; guard++; end
      chk("rst_pre_req", 64'(phy_req_o), 64'd1);
      rst_ni = 1'b0;
      exp_q.delete();
      exp_err_addr = '0;
      #1;
      chk("rst_async", {mp_req_o, mp_addr_o, phy_req_o, phy_op_o, phy_addr_o,
                        busy_o, op_done_o, op_err_o, err_addr_o}, 64'd0);
      repeat (2) @(negedge clk_i);
      #1 rst_ni = 1'b1;
      done_cyc = -1;
      repeat (4) @(negedge clk_i);
      chk("rst_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

      start_op(2'd1, 16'h0300, 12'd1, 2, 1'b0, 16'h0, sc);
      wait_op();
      chk("post_rst_count", 64'(obs_q.size()), 64'd2);
      chk_err_addr();

      repeat (2) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/flash_mp_op_ctrl.md
# flash_mp_op_ctrl

Initiator-side operation sequencer for the flash memory-protection path. It accepts a host flash operation (read, program or erase) and walks its word addresses. For each word it presents the address to the data-region selector and samples the returned per-operation enables. Permitted words are forwarded to the flash PHY with a req/ack handshake. A denied word aborts the operation with an error and records the failing address.

## Interface
Parameters:
- AddrW, 16, flash word-address width
- CntW, 12, word-count width; op_num_words_i uses N-1 encoding

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- op_start_i  in  1  one-cycle start pulse; honoured only when busy_o=0
- op_type_i  in  2  flash_mp_pkg::op_e: OpRead=0, OpProg=1, OpErase=2, 3 reserved
- op_addr_i  in  AddrW  first word address
- op_num_words_i  in  CntW  word count minus one; ignored for erase
- mp_req_o  out  1  address-check strobe to the region selector
- mp_addr_o  out  AddrW  address under check
- mp_rd_en_i, mp_prog_en_i, mp_erase_en_i  in  1 each  region-selector enables, valid in the cycle mp_req_o=1
- phy_req_o  out  1  PHY request; held until acknowledged
- phy_op_o  out  2  operation type to the PHY
- phy_addr_o  out  AddrW  PHY word address
- phy_ack_i  in  1  PHY acknowledge
- busy_o  out  1  operation in progress
- op_done_o  out  1  one-cycle completion pulse; pulses on success and on error
- op_err_o  out  1  one-cycle pulse, coincident with op_done_o, on a denied or reserved operation
- err_addr_o  out  AddrW  address of the last denied word

## Operation
- FSM states: Idle, Check, Issue, Done, Err.
- Idle:
  - On op_start_i: latch type, address and count; clear the word counter; go to Check.
- Check:
  - Drive mp_req_o=1 and mp_addr_o=current address.
  - Select the enable matching the latched type.
  - Enable=1 -> Issue. Enable=0 or reserved type -> Err.
- Issue:
  - Drive phy_req_o=1, phy_op_o=type, phy_addr_o=current address. These stay stable until phy_ack_i.
  - On ack, go to Done if the type is erase or counter == num_words. Otherwise increment the address and counter, then return to Check.
- Every word is re-checked, because region boundaries can fall inside an operation.
- Done: op_done_o=1 for one cycle, then Idle.
- Err: op_done_o=1 and op_err_o=1 for one cycle, and err_addr_o captures the current address; then Idle.
- Address increments modulo 2^AddrW, so 0xFFFF wraps to 0x0000 with no error.
- busy_o=1 in every state except Idle.
- op_start_i while busy is dropped; it is neither queued nor an error.
- phy_ack_i outside Issue is ignored.

## Timing
- Reset values: all outputs 0, state Idle, err_addr_o 0.
- Reset mid-operation: phy_req_o and mp_req_o deassert asynchronously, and the operation is discarded without a done pulse.
- Start at cycle 0 (Idle):
  - mp_req_o=1 at cycle 1.
  - phy_req_o=1 at cycle 2.
  - If ack arrives at cycle k, the next mp_req_o is at k+1. For the last word, op_done_o is at k+1 and busy_o=0 at k+2.
- Denial at cycle c: op_done_o and op_err_o at c+1; busy_o=0 at c+2.
- Minimum per-word cost: 2 cycles (Check plus a same-cycle ack in Issue).
- mp_*_en_i is sampled combinationally in Check. The region selector is combinational and is not registered in this block.

## Configuration
- FLASH_MP_ERR_ADDR_EN defined: the err_addr_o register is implemented and holds the last denied address until the next denial or reset.
- Undefined: err_addr_o is tied to 0 and the register is removed. All other behaviour is identical.

## Structure
- flash_mp_pkg holds op_e and the state enum (state_e) for the five FSM states.
- One sub-module, flash_mp_addr_cnt, holds the address register, the word counter, load/increment control and the last-word compare.
- Top-level flash_mp_op_ctrl holds the FSM, output decode and the error-address register.

## Test plan
- Read, addr 0x0010, num 3, all enables 1, immediate ack:
  - Four mp_req_o/phy_req_o pairs, at 0x0010 through 0x0013.
  - op_done_o 9 cycles after start; op_err_o stays 0.
- Program, addr 0x0020, num 1; mp_prog_en_i=0 for address 0x0021:
  - One PHY request, to 0x0020.
  - op_err_o and op_done_o pulse together; err_addr_o=0x0021, or 0 with the macro undefined.
- Erase, addr 0x0100, num 5: exactly one PHY request, phy_op_o=2, then op_done_o.
- Read, addr 0xFFFF, num 1: PHY addresses 0xFFFF then 0x0000; no error.
- op_start_i pulsed during Issue, and phy_ack_i delayed 4 cycles: the second start is ignored, and phy_req_o and phy_addr_o stay stable for all 4 cycles.
- rst_ni asserted while phy_req_o=1:
  - All outputs go to 0 immediately and no done pulse follows.
  - A new start after reset completes normally.
